seq_left_shifter: RTL and testbench

//  Multi-cycle logical left shifter; the left-direction counterpart of the datapath's right shifters.

---
 rtl/seq_left_shifter.sv | 97 +++++++++
 tb/tb_seq_left_shifter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_left_shifter.sv
// Multi-cycle logical left shifter: one power-of-two stage per clock.
// Ports: clk, rst, start/a/b in; ready/busy/done, s = a << b, ovf out.
module seq_left_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [WIDTH-1:0]     acc;
  logic [SHAMT_W-1:0]   amt;
  logic [SHAMT_W-1:0]   stage_oh;
  logic                 ovf_acc;
  logic                 oor;
  logic                 a_nz;
  logic [WIDTH-1:0]     shifted;
  logic                 lost;
  logic                 load;

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == SHIFT);
  assign done  = (state == DONE);
  assign load  = ready && start;

  // Stage k is tracked one-hot; stage k shifts by 2^k when amt[k] is set.
  always_comb begin
    shifted = acc;
    lost    = 1'b0;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (stage_oh[i] && amt[i]) begin
        shifted = acc << (2 ** i);
        lost    = |(acc >> (WIDTH - 2 ** i));
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (stage_oh[SHAMT_W-1]) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      amt      <= '0;
      stage_oh <= '0;
      ovf_acc  <= 1'b0;
      oor      <= 1'b0;
      a_nz     <= 1'b0;
      s        <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        acc      <= a;
        amt      <= b[SHAMT_W-1:0];
        // Amounts >= WIDTH still run every stage; only the result is forced.
        oor      <= |b[WIDTH-1:SHAMT_W];
        a_nz     <= |a;
        stage_oh <= {{(SHAMT_W-1){1'b0}}, 1'b1};
        ovf_acc  <= 1'b0;
      end else if (state == SHIFT) begin
        acc      <= shifted;
        ovf_acc  <= ovf_acc | lost;
        stage_oh <= stage_oh << 1;
        if (stage_oh[SHAMT_W-1]) begin
          s   <= oor ? '0 : shifted;
          ovf <= oor ? a_nz : (ovf_acc | lost);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed testbench for seq_left_shifter.
// Each task drives one scenario and checks results inline.
module tb_seq_left_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] s;
  logic        ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_left_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Drive start for one cycle; returns at the negedge after the sampling edge.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges until done; -1 if it never arrives.
  task automatic wait_done(input int init, output int cyc);
    cyc = init;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({s, ovf, done, busy, ready} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: s=%h ovf=%b done=%b busy=%b ready=%b",
               s, ovf, done, busy, ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_vec(input string nm, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] es,
                          input logic eo);
    int cyc;
    start_op(av, bv);
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy: busy=%b ready=%b want 1/0", nm, busy, ready);
    end
    wait_done(0, cyc);
    n_cmp++;
    if (cyc !== 5) begin
      n_bad++;
      $display("FAIL %s_lat: got %0d want 5", nm, cyc);
    end
    n_cmp++;
    if (s !== es || ovf !== eo) begin
      n_bad++;
      $display("FAIL %s: s=%h ovf=%b want s=%h ovf=%b", nm, s, ovf, es, eo);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || ready !== 1'b1 || s !== es) begin
      n_bad++;
      $display("FAIL %s_after: done=%b ready=%b s=%h want 0/1/%h",
               nm, done, ready, s, es);
    end
  endtask

  task automatic test_basic();
    test_vec("basic", 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b0);
  endtask

  task automatic test_overflow();
    test_vec("ovf_top", 32'h8000_0001, 32'd1, 32'h0000_0002, 1'b1);
    test_vec("ovf_31", 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 1'b1);
  endtask

  task automatic test_zero_shift();
    test_vec("b_zero", 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
  endtask

  task automatic test_out_of_range();
    test_vec("oor_32", 32'h0000_0001, 32'd32, 32'h0, 1'b1);
    test_vec("oor_zero_a", 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    start_op(32'd1, 32'd3);
    @(negedge clk);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, cyc);
    n_cmp++;
    if (cyc !== 5 || s !== 32'h8 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_ignore: lat=%0d s=%h ovf=%b want 5/00000008/0",
               cyc, s, ovf);
    end
    cyc = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cyc++;
    end
    n_cmp++;
    if (cyc !== 0) begin
      n_bad++;
      $display("FAIL busy_dropped: extra done pulses=%0d want 0", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_op(32'd5, 32'd2);
    wait_done(0, cyc);
    n_cmp++;
    if (cyc !== 5 || s !== 32'h14) begin
      n_bad++;
      $display("FAIL b2b_first: lat=%0d s=%h want 5/00000014", cyc, s);
    end
    start = 1'b1;
    a     = 32'd3;
    b     = 32'd2;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || s !== 32'h14) begin
      n_bad++;
      $display("FAIL b2b_hold: busy=%b done=%b s=%h want 1/0/00000014",
               busy, done, s);
    end
    wait_done(0, cyc);
    n_cmp++;
    if (cyc !== 5 || s !== 32'hC || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: lat=%0d s=%h ovf=%b want 5/0000000c/0",
               cyc, s, ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    test_vec("pre_rst", 32'h8000_0003, 32'd2, 32'h0000_000C, 1'b1);
    start_op(32'd1, 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({s, ovf, done, busy, ready} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_async: s=%h ovf=%b done=%b busy=%b ready=%b",
               s, ovf, done, busy, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cyc++;
    end
    n_cmp++;
    if (cyc !== 0) begin
      n_bad++;
      $display("FAIL rst_no_done: done pulses=%0d want 0", cyc);
    end
    test_vec("post_rst", 32'd2, 32'd2, 32'h8, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_shift();
    test_out_of_range();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
